// File: rtl/bp_types.sv
// Shared types for the branch-prediction resolution path: queue entry layout,
// resolver state encoding and the RV32I opcode set seen in EX.
package bp_types;

    localparam int BP_HIST_W = 7;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          pred_next;
        logic [BP_HIST_W-1:0] hist;
    } pred_entry_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } br_state_t;

endpackage

// File: rtl/pred_queue.sv
// In-order prediction queue: circular buffer with wrap-bit pointers, registered
// full flag, and a truncate port that moves both pointers to a given position.
module pred_queue
    import bp_types::*;
#(
    parameter int s_depth = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_en,
    input  pred_entry_t        push_data,
    input  logic               pop_en,
    input  logic               trunc_en,
    input  logic [s_depth:0]   trunc_ptr,
    output pred_entry_t        head,
    output logic [s_depth:0]   rd_ptr,
    output logic               full,
    output logic               empty
);
    localparam int DEPTH = 1 << s_depth;

    pred_entry_t        mem_q [DEPTH];
    logic [s_depth:0]   rd_ptr_q, rd_ptr_d;
    logic [s_depth:0]   wr_ptr_q, wr_ptr_d;
    logic               full_q, full_d;
    logic               do_push, do_pop;

    assign empty = (rd_ptr_q == wr_ptr_q);

    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    always_comb begin
        do_pop   = pop_en && !empty;
        // A pop in the same cycle frees the slot, so a push is legal even when full.
        do_push  = push_en && !trunc_en && (!full_q || do_pop);
        rd_ptr_d = rd_ptr_q + {{s_depth{1'b0}}, do_pop};
        wr_ptr_d = wr_ptr_q + {{s_depth{1'b0}}, do_push};
        if (trunc_en) begin
            rd_ptr_d = trunc_ptr;
            wr_ptr_d = trunc_ptr;
        end
        full_d = ((rd_ptr_d ^ wr_ptr_d) == {1'b1, {s_depth{1'b0}}});
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            full_q   <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            full_q   <= full_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which slots are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[s_depth-1:0]] <= push_data;
        end
    end

    assign head   = mem_q[rd_ptr_q[s_depth-1:0]];
    assign rd_ptr = rd_ptr_q;
    assign full   = full_q;

endmodule

// File: rtl/branch_resolver.sv
// Pops the prediction queue on EX resolution, flags mispredicts, drives the BTB
// update port and the redirect/flush. Define BP_PERF_CNT_EN for perf counters.
module branch_resolver
    import bp_types::*;
#(
    parameter int s_depth   = 3,
    parameter int s_history = BP_HIST_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 predict_en,
    input  logic [31:0]          curr_pc,
    input  logic [31:0]          predicted_next_pc,
    input  logic [s_history-1:0] g_history,
    input  logic                 ex_valid,
    input  logic [31:0]          ex_pc,
    input  logic [31:0]          ex_next_pc,
    input  rv32i_opcode          EX_opcode,
    output logic [31:0]          resolved_pc,
    output logic                 predictionFailed,
    output logic [31:0]          expected_next_pc,
    output logic [s_history-1:0] resolved_g_history,
    output logic [6:0]           resolved_opcode,
    output logic                 flush,
    output logic [31:0]          redirect_pc,
    output logic                 queue_full,
    output logic                 queue_err
`ifdef BP_PERF_CNT_EN
    ,
    output logic [31:0]          perf_resolved,
    output logic [31:0]          perf_mispredict
`endif
);
    pred_entry_t          push_entry, q_head;
    logic [s_depth:0]     q_rd_ptr, trunc_ptr;
    logic                 q_full, q_empty;
    logic                 run, pop, pop_ok, empty_pop, fail, push;

    br_state_t            state_q, state_d;
    logic                 pred_failed_q, pred_failed_d;
    logic                 flush_q, flush_d;
    logic                 queue_err_q, queue_err_d;
    logic [31:0]          resolved_pc_q, resolved_pc_d;
    logic [31:0]          expected_next_pc_q, expected_next_pc_d;
    logic [s_history-1:0] resolved_hist_q, resolved_hist_d;
    logic [6:0]           resolved_opcode_q, resolved_opcode_d;

    always_comb begin
        push_entry.pc        = curr_pc;
        push_entry.pred_next = predicted_next_pc;
        push_entry.hist      = BP_HIST_W'(g_history);

        run       = (state_q == RUN);
        pop       = ex_valid && run;
        empty_pop = pop && q_empty;
        pop_ok    = pop && !q_empty;
        // A tag mismatch is as much a failure as a wrong target.
        fail      = empty_pop
                 || (pop_ok && ((ex_next_pc != q_head.pred_next) || (ex_pc != q_head.pc)));
        push      = predict_en && run && !fail;
        trunc_ptr = q_rd_ptr + {{s_depth{1'b0}}, pop_ok};

        state_d            = fail ? RECOVER : RUN;
        pred_failed_d      = fail;
        flush_d            = fail;
        queue_err_d        = queue_err_q || empty_pop;
        resolved_pc_d      = resolved_pc_q;
        expected_next_pc_d = expected_next_pc_q;
        resolved_hist_d    = resolved_hist_q;
        resolved_opcode_d  = resolved_opcode_q;
        if (pop) begin
            resolved_pc_d      = ex_pc;
            expected_next_pc_d = ex_next_pc;
            resolved_hist_d    = q_empty ? '0 : s_history'(q_head.hist);
            resolved_opcode_d  = EX_opcode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= RUN;
            pred_failed_q      <= 1'b0;
            flush_q            <= 1'b0;
            queue_err_q        <= 1'b0;
            resolved_pc_q      <= '0;
            expected_next_pc_q <= '0;
            resolved_hist_q    <= '0;
            resolved_opcode_q  <= '0;
        end else begin
            state_q            <= state_d;
            pred_failed_q      <= pred_failed_d;
            flush_q            <= flush_d;
            queue_err_q        <= queue_err_d;
            resolved_pc_q      <= resolved_pc_d;
            expected_next_pc_q <= expected_next_pc_d;
            resolved_hist_q    <= resolved_hist_d;
            resolved_opcode_q  <= resolved_opcode_d;
        end
    end

    pred_queue #(.s_depth(s_depth)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push_en   (push),
        .push_data (push_entry),
        .pop_en    (pop),
        .trunc_en  (fail),
        .trunc_ptr (trunc_ptr),
        .head      (q_head),
        .rd_ptr    (q_rd_ptr),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign resolved_pc        = resolved_pc_q;
    assign predictionFailed   = pred_failed_q;
    assign expected_next_pc   = expected_next_pc_q;
    assign redirect_pc        = expected_next_pc_q;
    assign resolved_g_history = resolved_hist_q;
    assign resolved_opcode    = resolved_opcode_q;
    assign flush              = flush_q;
    assign queue_full         = q_full;
    assign queue_err          = queue_err_q;

`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_resolved_q, perf_resolved_d;
    logic [31:0] perf_mispredict_q, perf_mispredict_d;

    always_comb begin
        perf_resolved_d   = perf_resolved_q;
        perf_mispredict_d = perf_mispredict_q;
        if (pop && (perf_resolved_q != '1)) perf_resolved_d = perf_resolved_q + 32'd1;
        if (fail && (perf_mispredict_q != '1)) perf_mispredict_d = perf_mispredict_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_resolved_q   <= '0;
            perf_mispredict_q <= '0;
        end else begin
            perf_resolved_q   <= perf_resolved_d;
            perf_mispredict_q <= perf_mispredict_d;
        end
    end

    assign perf_resolved   = perf_resolved_q;
    assign perf_mispredict = perf_mispredict_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios plus randomized
// traffic against a queue-level reference model.
module tb_branch_resolver;
    import bp_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        predict_en;
    logic [31:0] curr_pc, predicted_next_pc;
    logic [6:0]  g_history;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_next_pc;
    rv32i_opcode ex_opcode;
    logic [31:0] resolved_pc, expected_next_pc, redirect_pc;
    logic        predictionFailed, flush, queue_full, queue_err;
    logic [6:0]  resolved_g_history, resolved_opcode;
`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_resolved, perf_mispredict;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pn;
        logic [6:0]  hist;
    } m_entry_t;

    m_entry_t    mq[$];
    bit          m_recover, e_pf, e_flush, e_full, e_err;
    logic [31:0] e_rpc, e_enpc;
    logic [6:0]  e_hist, e_op;
    int unsigned e_pops, e_misp;

    branch_resolver dut (
        .clk                (clk),
        .rst                (rst),
        .predict_en         (predict_en),
        .curr_pc            (curr_pc),
        .predicted_next_pc  (predicted_next_pc),
        .g_history          (g_history),
        .ex_valid           (ex_valid),
        .ex_pc              (ex_pc),
        .ex_next_pc         (ex_next_pc),
        .EX_opcode          (ex_opcode),
        .resolved_pc        (resolved_pc),
        .predictionFailed   (predictionFailed),
        .expected_next_pc   (expected_next_pc),
        .resolved_g_history (resolved_g_history),
        .resolved_opcode    (resolved_opcode),
        .flush              (flush),
        .redirect_pc        (redirect_pc),
        .queue_full         (queue_full),
        .queue_err          (queue_err)
`ifdef BP_PERF_CNT_EN
        ,
        .perf_resolved      (perf_resolved),
        .perf_mispredict    (perf_mispredict)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        mq.delete();
        m_recover = 0; e_pf = 0; e_flush = 0; e_full = 0; e_err = 0;
        e_rpc = 0; e_enpc = 0; e_hist = 0; e_op = 0; e_pops = 0; e_misp = 0;
    endtask

    // One clock of the specification's behaviour, expressed as queue operations.
    task automatic model_step(input bit pe, input logic [31:0] pc, input logic [31:0] pn,
                              input logic [6:0] h, input bit ev, input logic [31:0] epc,
                              input logic [31:0] enpc, input logic [6:0] op);
        bit fail;
        m_entry_t e;
        fail = 0;
        if (!m_recover && ev) begin
            if (e_pops != 32'hFFFF_FFFF) e_pops++;
            e_rpc = epc; e_enpc = enpc; e_op = op;
            if (mq.size() == 0) begin
                fail = 1; e_err = 1; e_hist = 0;
            end else begin
                e = mq.pop_front();
                e_hist = e.hist;
                fail = (e.pc != epc) || (e.pn != enpc);
            end
        end
        if (!m_recover && pe && !fail && mq.size() < 8) mq.push_back('{pc, pn, h});
        if (fail) begin
            mq.delete();
            if (e_misp != 32'hFFFF_FFFF) e_misp++;
        end
        e_pf = fail; e_flush = fail; m_recover = fail; e_full = (mq.size() == 8);
    endtask

    task automatic drive_cycle(input bit pe, input logic [31:0] pc, input logic [31:0] pn,
                               input logic [6:0] h, input bit ev, input logic [31:0] epc,
                               input logic [31:0] enpc, input rv32i_opcode op);
        predict_en = pe; curr_pc = pc; predicted_next_pc = pn; g_history = h;
        ex_valid = ev; ex_pc = epc; ex_next_pc = enpc; ex_opcode = op;
        model_step(pe, pc, pn, h, ev, epc, enpc, op);
        @(posedge clk);
        #1;
    endtask

    task automatic push_only(input logic [31:0] pc, input logic [31:0] pn, input logic [6:0] h);
        drive_cycle(1, pc, pn, h, 0, 32'h0, 32'h0, op_br);
    endtask

    task automatic resolve(input logic [31:0] epc, input logic [31:0] enpc);
        drive_cycle(0, 32'h0, 32'h0, 7'h0, 1, epc, enpc, op_br);
    endtask

    task automatic idle();
        drive_cycle(0, 32'h0, 32'h0, 7'h0, 0, 32'h0, 32'h0, op_br);
    endtask

    task automatic apply_reset();
        #2;
        rst = 1;
        predict_en = 0; ex_valid = 0; curr_pc = 0; predicted_next_pc = 0;
        g_history = 0; ex_pc = 0; ex_next_pc = 0; ex_opcode = op_br;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [108:0] all_out;
        apply_reset();
        all_out = {resolved_pc, expected_next_pc, redirect_pc, resolved_g_history,
                   resolved_opcode, predictionFailed, flush, queue_full, queue_err};
        n_checks++;
        if (all_out !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want all zero", all_out);
        end
`ifdef BP_PERF_CNT_EN
        n_checks++;
        if ({perf_resolved, perf_mispredict} !== 64'h0) begin
            n_fail++; $display("FAIL reset_perf: got %h/%h want 0/0", perf_resolved, perf_mispredict);
        end
`endif
    endtask

    task automatic test_in_order();
        for (int i = 0; i < 3; i++) push_only(32'h100 + 4 * i, 32'h104 + 4 * i, 7'(i + 1));
        for (int i = 0; i < 3; i++) begin
            resolve(32'h100 + 4 * i, 32'h104 + 4 * i);
            n_checks++;
            if (predictionFailed !== 1'b0 || flush !== 1'b0) begin
                n_fail++; $display("FAIL inorder_pf[%0d]: got pf=%b flush=%b want 0/0", i, predictionFailed, flush);
            end
            n_checks++;
            if (resolved_pc !== 32'h100 + 4 * i || resolved_g_history !== 7'(i + 1)) begin
                n_fail++; $display("FAIL inorder_data[%0d]: got pc=%h hist=%h want %h/%h",
                                   i, resolved_pc, resolved_g_history, 32'h100 + 4 * i, i + 1);
            end
        end
    endtask

    // Follows test_in_order, so the pop also confirms that the queue drained.
    task automatic test_pop_empty();
        resolve(32'h0, 32'h44);
        n_checks++;
        if (predictionFailed !== 1'b1 || queue_err !== 1'b1 || flush !== 1'b1) begin
            n_fail++; $display("FAIL empty_pop: got pf=%b err=%b flush=%b want 1/1/1", predictionFailed, queue_err, flush);
        end
        n_checks++;
        if (resolved_g_history !== 7'h0 || expected_next_pc !== 32'h44) begin
            n_fail++; $display("FAIL empty_pop_data: got hist=%h enpc=%h want 0/44", resolved_g_history, expected_next_pc);
        end
        idle();
        n_checks++;
        if (queue_err !== 1'b1 || predictionFailed !== 1'b0 || flush !== 1'b0) begin
            n_fail++; $display("FAIL empty_pop_sticky: got err=%b pf=%b flush=%b want 1/0/0", queue_err, predictionFailed, flush);
        end
        push_only(32'h500, 32'h504, 7'h11);
        resolve(32'h500, 32'h504);
        n_checks++;
        if (predictionFailed !== 1'b0 || resolved_pc !== 32'h500 || queue_err !== 1'b1) begin
            n_fail++; $display("FAIL empty_pop_recover: got pf=%b pc=%h err=%b want 0/500/1", predictionFailed, resolved_pc, queue_err);
        end
    endtask

    task automatic test_mispredict();
        push_only(32'h200, 32'h204, 7'h15);
        push_only(32'h204, 32'h208, 7'h2A);
        resolve(32'h200, 32'h300);
        n_checks++;
        if (predictionFailed !== 1'b1 || flush !== 1'b1) begin
            n_fail++; $display("FAIL mispredict_pf: got pf=%b flush=%b want 1/1", predictionFailed, flush);
        end
        n_checks++;
        if (resolved_pc !== 32'h200 || expected_next_pc !== 32'h300 || redirect_pc !== 32'h300
            || resolved_g_history !== 7'h15) begin
            n_fail++; $display("FAIL mispredict_data: got pc=%h enpc=%h redir=%h hist=%h want 200/300/300/15",
                               resolved_pc, expected_next_pc, redirect_pc, resolved_g_history);
        end
        idle();
        n_checks++;
        if (predictionFailed !== 1'b0 || flush !== 1'b0 || expected_next_pc !== 32'h300) begin
            n_fail++; $display("FAIL mispredict_pulse: got pf=%b flush=%b enpc=%h want 0/0/300", predictionFailed, flush, expected_next_pc);
        end
        // The 0x204 entry must be gone: resolving it is an empty pop.
        resolve(32'h204, 32'h208);
        n_checks++;
        if (predictionFailed !== 1'b1 || resolved_g_history !== 7'h0) begin
            n_fail++; $display("FAIL mispredict_discard: got pf=%b hist=%h want 1/0", predictionFailed, resolved_g_history);
        end
        idle();
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            push_only(32'h1000 + 4 * i, 32'h1004 + 4 * i, 7'(i));
            if (i >= 6) begin
                n_checks++;
                if (queue_full !== (i == 7)) begin
                    n_fail++; $display("FAIL full_fill[%0d]: got %b want %b", i, queue_full, i == 7);
                end
            end
        end
        push_only(32'h2000, 32'h2004, 7'h7F);
        n_checks++;
        if (queue_full !== 1'b1) begin
            n_fail++; $display("FAIL full_drop: got %b want 1", queue_full);
        end
        drive_cycle(1, 32'h1020, 32'h1024, 7'h08, 1, 32'h1000, 32'h1004, op_br);
        n_checks++;
        if (queue_full !== 1'b1 || predictionFailed !== 1'b0) begin
            n_fail++; $display("FAIL full_pushpop: got full=%b pf=%b want 1/0", queue_full, predictionFailed);
        end
        for (int i = 1; i < 9; i++) begin
            resolve(32'h1000 + 4 * i, 32'h1004 + 4 * i);
            n_checks++;
            if (predictionFailed !== 1'b0 || resolved_g_history !== 7'(i) || queue_full !== 1'b0) begin
                n_fail++; $display("FAIL full_order[%0d]: got pf=%b hist=%h full=%b want 0/%h/0",
                                   i, predictionFailed, resolved_g_history, queue_full, i);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [108:0] all_out;
        for (int i = 0; i < 5; i++) push_only(32'h3000 + 4 * i, 32'h3004 + 4 * i, 7'(i));
        resolve(32'h3000, 32'h3100);
        #2;
        rst = 1;
        #1;
        all_out = {resolved_pc, expected_next_pc, redirect_pc, resolved_g_history,
                   resolved_opcode, predictionFailed, flush, queue_full, queue_err};
        n_checks++;
        if (all_out !== '0) begin
            n_fail++; $display("FAIL reset_mid_async: got %h want all zero", all_out);
        end
        model_reset();
        #2;
        rst = 0;
        push_only(32'h600, 32'h604, 7'h33);
        resolve(32'h600, 32'h604);
        n_checks++;
        if (predictionFailed !== 1'b0 || flush !== 1'b0 || resolved_pc !== 32'h600 || resolved_g_history !== 7'h33) begin
            n_fail++; $display("FAIL reset_mid_resume: got pf=%b flush=%b pc=%h hist=%h want 0/0/600/33",
                               predictionFailed, flush, resolved_pc, resolved_g_history);
        end
    endtask

    task automatic test_random();
        rv32i_opcode ops[3] = '{op_br, op_jal, op_jalr};
        bit pe, ev;
        logic [31:0] pc, pn, epc, enpc;
        logic [6:0] h;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            pe = ($urandom_range(0, 99) < 60);
            pc = $urandom & 32'hFFFF_FFFC;
            pn = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : pc + 32'd4;
            h = 7'($urandom);
            if (mq.size() > 0) begin
                ev = ($urandom_range(0, 99) < 45);
                epc = ($urandom_range(0, 9) == 0) ? ($urandom & 32'hFFFF_FFFC) : mq[0].pc;
                enpc = ($urandom_range(0, 5) == 0) ? ($urandom & 32'hFFFF_FFFC) : mq[0].pn;
            end else begin
                ev = ($urandom_range(0, 29) == 0);
                epc = $urandom; enpc = $urandom;
            end
            drive_cycle(pe, pc, pn, h, ev, epc, enpc, ops[$urandom_range(0, 2)]);
            n_checks++;
            if (predictionFailed !== e_pf || flush !== e_flush || queue_full !== e_full || queue_err !== e_err) begin
                n_fail++; $display("FAIL rand_ctrl[%0d]: got pf=%b fl=%b full=%b err=%b want %b/%b/%b/%b",
                                   c, predictionFailed, flush, queue_full, queue_err, e_pf, e_flush, e_full, e_err);
            end
            n_checks++;
            if (resolved_pc !== e_rpc || expected_next_pc !== e_enpc || redirect_pc !== e_enpc
                || resolved_g_history !== e_hist || resolved_opcode !== e_op) begin
                n_fail++; $display("FAIL rand_data[%0d]: got %h/%h/%h/%h/%h want %h/%h/%h/%h/%h", c,
                                   resolved_pc, expected_next_pc, redirect_pc, resolved_g_history, resolved_opcode,
                                   e_rpc, e_enpc, e_enpc, e_hist, e_op);
            end
`ifdef BP_PERF_CNT_EN
            n_checks++;
            if (perf_resolved !== e_pops || perf_mispredict !== e_misp) begin
                n_fail++; $display("FAIL rand_perf[%0d]: got %0d/%0d want %0d/%0d", c,
                                   perf_resolved, perf_mispredict, e_pops, e_misp);
            end
`endif
        end
    endtask

`ifdef BP_PERF_CNT_EN
    task automatic test_perf();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            push_only(32'h700 + 4 * i, 32'h704 + 4 * i, 7'(i));
            if (i == 2 || i == 5 || i == 8) begin
                resolve(32'h700 + 4 * i, 32'hDEAD_0000);
                idle();
            end else begin
                resolve(32'h700 + 4 * i, 32'h704 + 4 * i);
            end
        end
        n_checks++;
        if (perf_resolved !== 32'd10 || perf_mispredict !== 32'd3) begin
            n_fail++; $display("FAIL perf_counts: got %0d/%0d want 10/3", perf_resolved, perf_mispredict);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_in_order();
        test_pop_empty();
        test_mispredict();
        test_full();
        test_reset_mid();
        test_random();
`ifdef BP_PERF_CNT_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
